board_judge: RTL and testbench

- Read-side counterpart to the per-square mark registers. It consumes the flattened 9-square board those registers drive and decides the game outcome.
- On a one-cycle `check` request it takes a snapshot of the board and scans the 8 winning lines, one line per cycle.
- It then reports winner, winning line, draw or error with a one-cycle `done` pulse.
- It sits between the 3x3 square array and the game/turn controller and display logic.

---
 rtl/board_judge.sv | 134 +++++++++++++
 tb/tb_board_judge.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/board_judge.sv
`default_nettype none
// ============================================================================
//  Module      : board_judge
//  Description : Snapshots a 3x3 mark board on request and scans its eight
//                winning lines one per cycle, reporting winner, winning
//                line, draw or illegal-square error with a done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module board_judge #(
  parameter bit HOLD_RESULT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        check,
  input  logic [17:0] board,
  output logic        busy,
  output logic        done,
  output logic [1:0]  winner,
  output logic [2:0]  win_line,
  output logic        draw,
  output logic        error
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] c_LAST_LINE = 3'd7;

  state_t      r_state;
  logic [2:0]  r_idx;
  logic [17:0] r_snap;

  logic [3:0]  w_ia, w_ib, w_ic;
  logic [1:0]  w_a, w_b, w_c;
  logic        w_win;
  logic [8:0]  w_in_illegal;
  logic [8:0]  w_snap_empty;

  // Per-square flags: illegal marks on the live board (sampled at capture)
  // and empty squares in the frozen snapshot (used for the draw decision).
  for (genvar gi = 0; gi < 9; gi++) begin : g_sq
    assign w_in_illegal[gi] = (board[2*gi +: 2] == 2'b11);
    assign w_snap_empty[gi] = (r_snap[2*gi +: 2] == 2'b00);
  end

  // Map the current line index to its three square positions.
  always_comb begin
    w_ia = 4'd2;
    w_ib = 4'd4;
    w_ic = 4'd6;
    case (r_idx)
      3'd0:    begin w_ia = 4'd0; w_ib = 4'd1; w_ic = 4'd2; end
      3'd1:    begin w_ia = 4'd3; w_ib = 4'd4; w_ic = 4'd5; end
      3'd2:    begin w_ia = 4'd6; w_ib = 4'd7; w_ic = 4'd8; end
      3'd3:    begin w_ia = 4'd0; w_ib = 4'd3; w_ic = 4'd6; end
      3'd4:    begin w_ia = 4'd1; w_ib = 4'd4; w_ic = 4'd7; end
      3'd5:    begin w_ia = 4'd2; w_ib = 4'd5; w_ic = 4'd8; end
      3'd6:    begin w_ia = 4'd0; w_ib = 4'd4; w_ic = 4'd8; end
      default: begin w_ia = 4'd2; w_ib = 4'd4; w_ic = 4'd6; end
    endcase
  end

  assign w_a   = r_snap[{w_ia, 1'b0} +: 2];
  assign w_b   = r_snap[{w_ib, 1'b0} +: 2];
  assign w_c   = r_snap[{w_ic, 1'b0} +: 2];
  // Illegal (2'b11) and empty squares can never complete a line.
  assign w_win = (w_a == w_b) && (w_b == w_c) && ((w_a == 2'b01) || (w_a == 2'b10));

  // Scan controller with registered result outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_idx    <= 3'd0;
      r_snap   <= 18'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      winner   <= 2'b00;
      win_line <= 3'd0;
      draw     <= 1'b0;
      error    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (check) begin
            r_snap   <= board;
            error    <= |w_in_illegal;
            winner   <= 2'b00;
            win_line <= 3'd0;
            draw     <= 1'b0;
            r_idx    <= 3'd0;
            busy     <= 1'b1;
            r_state  <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_win) begin
            winner   <= w_a;
            win_line <= r_idx;
            done     <= 1'b1;
            r_state  <= S_DONE;
          end else if (r_idx == c_LAST_LINE) begin
            draw     <= ~(|w_snap_empty) && !error;
            done     <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_idx    <= r_idx + 3'd1;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
          if (!HOLD_RESULT) begin
            winner   <= 2'b00;
            win_line <= 3'd0;
            draw     <= 1'b0;
            error    <= 1'b0;
          end
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_board_judge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_board_judge
//  Description : Scoreboard bench for board_judge (held and cleared results).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_board_judge;

  typedef struct {
    int         exp_cyc;
    int         lat;
    logic [1:0] w;
    logic [2:0] ln;
    logic       d;
    logic       e;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        check = 1'b0;
  logic [17:0] board = 18'd0;

  logic       busy, done, draw, error;
  logic [1:0] winner;
  logic [2:0] win_line;
  logic       busy0, done0, draw0, error0;
  logic [1:0] winner0;
  logic [2:0] win_line0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t sbq[$];

  int LINES[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                      '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  board_judge #(.HOLD_RESULT(1'b1)) dut (
    .clk(clk), .reset(reset), .check(check), .board(board),
    .busy(busy), .done(done), .winner(winner), .win_line(win_line),
    .draw(draw), .error(error));

  board_judge #(.HOLD_RESULT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .check(check), .board(board),
    .busy(busy0), .done(done0), .winner(winner0), .win_line(win_line0),
    .draw(draw0), .error(error0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Game-rule reference: first complete line of one player wins, otherwise
  // a full legal board is a draw.
  function automatic exp_t model(input logic [17:0] b);
    exp_t e;
    logic [1:0] s[9];
    bool_full: begin end
    for (int i = 0; i < 9; i++) s[i] = b[2*i +: 2];
    e.w = 2'b00; e.ln = 3'd0; e.d = 1'b0; e.e = 1'b0; e.lat = 9; e.exp_cyc = 0;
    for (int i = 0; i < 9; i++) if (s[i] == 2'b11) e.e = 1'b1;
    for (int l = 0; l < 8; l++) begin
      logic [1:0] p;
      p = s[LINES[l][0]];
      if ((p == 2'b01 || p == 2'b10) && s[LINES[l][1]] == p && s[LINES[l][2]] == p) begin
        e.w = p; e.ln = 3'(l); e.lat = 2 + l;
        return e;
      end
    end
    e.d = !e.e;
    for (int i = 0; i < 9; i++) if (s[i] == 2'b00) e.d = 1'b0;
    return e;
  endfunction

  function automatic logic [17:0] pack9(input logic [1:0] a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {a8, a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  function automatic logic [17:0] rand_board();
    logic [17:0] b;
    int r, l;
    logic [1:0] p;
    for (int i = 0; i < 9; i++) begin
      r = $urandom % 16;
      b[2*i +: 2] = (r < 5) ? 2'b00 : (r < 10) ? 2'b01 : (r < 15) ? 2'b10 : 2'b11;
    end
    if ($urandom % 3 == 0) begin
      l = $urandom % 8;
      p = ($urandom % 2 == 0) ? 2'b01 : 2'b10;
      for (int j = 0; j < 3; j++) b[2*LINES[l][j] +: 2] = p;
    end
    return b;
  endfunction

  task automatic check_idle_zero(input string nm);
    chk({nm, "_busy"}, busy, 0);   chk({nm, "_done"}, done, 0);
    chk({nm, "_winner"}, winner, 0); chk({nm, "_line"}, win_line, 0);
    chk({nm, "_draw"}, draw, 0);   chk({nm, "_error"}, error, 0);
    chk({nm, "_busy0"}, busy0, 0); chk({nm, "_done0"}, done0, 0);
    chk({nm, "_out0"}, {winner0, win_line0, draw0, error0}, 0);
  endtask

  // Issue one request and follow it to completion; optionally scramble the
  // live board and pulse check while the scan runs.
  task automatic run_txn(input logic [17:0] b, input bit noisy);
    exp_t e;
    int n;
    n = 0;
    while (busy && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("idle_wait_timeout", 1, 0);
    board = b;
    check = 1'b1;
    e = model(b);
    e.exp_cyc = cyc + e.lat;
    sbq.push_back(e);
    @(negedge clk);
    check = 1'b0;
    chk("busy_after_accept", busy, 1);
    chk("no_early_done", done, 0);
    n = 0;
    while (busy && n < 20) begin
      if (noisy) begin
        board = rand_board();
        check = ($urandom % 4 == 0);
      end
      @(negedge clk);
      n++;
    end
    check = 1'b0;
    if (n >= 20) chk("scan_timeout", 1, 0);
  endtask

  // Monitor: pops the scoreboard on every done and verifies latency, the
  // result fields and the post-done behaviour of both result modes.
  initial begin
    exp_t cur;
    bit post_pend;
    post_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (post_pend) begin
        post_pend = 1'b0;
        chk("hold_winner", winner, cur.w);
        chk("hold_line", win_line, cur.ln);
        chk("hold_draw", draw, cur.d);
        chk("hold_error", error, cur.e);
        chk("clear_outputs0", {winner0, win_line0, draw0, error0}, 0);
        chk("done_pulse_width", done, 0);
      end
      if (done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          cur = sbq.pop_front();
          chk("done_latency", cyc, cur.exp_cyc);
          chk("winner", winner, cur.w);
          chk("win_line", win_line, cur.ln);
          chk("draw", draw, cur.d);
          chk("error", error, cur.e);
          chk("busy_in_done", busy, 1);
          chk("done0", done0, 1);
          chk("result0", {winner0, win_line0, draw0, error0}, {cur.w, cur.ln, cur.d, cur.e});
          post_pend = 1'b1;
        end
      end else if (sbq.size() > 0 && cyc > sbq[0].exp_cyc) begin
        cur = sbq.pop_front();
        chk("done_missing", 0, 1);
      end
    end
  end

  initial begin
    exp_t e;
    logic [17:0] b;
    int n;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    // Empty board: no winner after all eight lines.
    run_txn(18'd0, 1'b0);
    // Top row player 1.
    run_txn(pack9(2'b10, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0), 1'b0);
    // Anti-diagonal player 0 on an otherwise full board.
    run_txn(pack9(2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10), 1'b0);
    // Full board, no line: draw; live board scrambled mid-scan.
    b = pack9(2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01);
    run_txn(b, 1'b1);
    // Re-check clears the held result on the cycle after accept.
    board = 18'd0;
    check = 1'b1;
    e = model(18'd0);
    e.exp_cyc = cyc + e.lat;
    sbq.push_back(e);
    @(negedge clk);
    check = 1'b0;
    chk("recheck_clear", {winner, win_line, draw, error}, 0);
    n = 0;
    while (busy && n < 20) begin @(negedge clk); n++; end
    // Illegal centre square with player-1 column 0, check pulsed during scan.
    run_txn(pack9(2'b10, 0, 0, 2'b10, 2'b11, 0, 2'b10, 0, 0), 1'b1);

    // Check held high: a second scan starts as soon as IDLE is re-entered.
    b = pack9(2'b01, 2'b01, 2'b01, 0, 0, 0, 0, 0, 0);
    e = model(b);
    check = 1'b1;
    board = b;
    e.exp_cyc = cyc + e.lat;
    sbq.push_back(e);
    e.exp_cyc = cyc + 2 * e.lat + 1;
    sbq.push_back(e);
    repeat (2 * e.lat + 1) @(negedge clk);
    check = 1'b0;
    n = 0;
    while (busy && n < 20) begin @(negedge clk); n++; end

    // Reset mid-scan aborts with no done.
    board = pack9(2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01);
    check = 1'b1;
    @(negedge clk);
    check = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle_zero("midscan_reset");
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_reset_idle", busy, 0);
    run_txn(pack9(0, 0, 2'b10, 0, 0, 2'b10, 0, 0, 2'b10), 1'b0);

    // Randomized boards with scan-time noise.
    for (int t = 0; t < 80; t++) run_txn(rand_board(), ($urandom % 2) == 1);

    repeat (12) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
